pulse_counter: RTL and testbench



---
 rtl/pulse_counter_pkg.sv | 12 +
 rtl/pulse_counter_tap.sv | 36 +++
 rtl/pulse_counter.sv | 49 ++++
 tb/tb_pulse_counter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_counter_pkg.sv
// Shared constants for the pulse_counter timebase: the strobe divisors
// (as log2 values, one entry per strobe output) and the smallest legal
// counter width, which must cover the widest divisor (16).
package pulse_counter_pkg;

   localparam int NUM_TAPS      = 4;
   localparam int MIN_CNT_WIDTH = 4;

   // Divide-by-2, 4, 8 and 16, ordered to match pulse2..pulse16.
   localparam int DIV_LOG2 [NUM_TAPS] = '{1, 2, 3, 4};

endpackage

// File: rtl/pulse_counter_tap.sv
// One strobe generator for pulse_counter. It watches the low LOG2_DIV bits
// of the shared counter and raises its strobe when they are all ones, which
// happens exactly once every 2**LOG2_DIV clocks.
// Build option: PULSE_COUNTER_COMB_OUT_EN selects a zero-latency
// combinational strobe; by default the strobe is registered (glitch-free,
// one cycle later than the tap).
module pulse_counter_tap #(
   parameter int LOG2_DIV = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LOG2_DIV-1:0] cnt,
   output logic                pulse
);

   logic tap;

   assign tap = (cnt == {LOG2_DIV{1'b1}});

`ifdef PULSE_COUNTER_COMB_OUT_EN
   logic unused_clk_rst;

   assign unused_clk_rst = clk ^ rst;
   assign pulse          = tap;
`else
   // Register the tap so downstream logic sees a clean single-cycle strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse <= 1'b0;
      end else begin
         pulse <= tap;
      end
   end
`endif

endmodule

// File: rtl/pulse_counter.sv
// pulse_counter: free-running binary counter that produces single-cycle
// strobes at 1/2, 1/4, 1/8 and 1/16 of the clock rate. The counter wraps
// modulo 2**CNT_WIDTH; since every divisor divides that modulus, strobe
// periods are unaffected by the wrap. CNT_WIDTH must be at least
// MIN_CNT_WIDTH so the divide-by-16 tap has enough counter bits.
// Build option: PULSE_COUNTER_COMB_OUT_EN (see pulse_counter_tap) removes
// the output register and makes the strobes combinational from the counter.
module pulse_counter
   import pulse_counter_pkg::*;
#(
   parameter int CNT_WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   output logic pulse2,
   output logic pulse4,
   output logic pulse8,
   output logic pulse16
);

   logic [CNT_WIDTH-1:0] cnt;
   logic [NUM_TAPS-1:0]  pulse_vec;

   // Free-running counter; reset restarts every strobe phase from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

   for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
      pulse_counter_tap #(
         .LOG2_DIV (DIV_LOG2[i])
      ) u_tap (
         .clk   (clk),
         .rst   (rst),
         .cnt   (cnt[DIV_LOG2[i]-1:0]),
         .pulse (pulse_vec[i])
      );
   end

   assign pulse2  = pulse_vec[0];
   assign pulse4  = pulse_vec[1];
   assign pulse8  = pulse_vec[2];
   assign pulse16 = pulse_vec[3];

endmodule

// File: tb/tb_pulse_counter.sv
// Testbench for pulse_counter. Two instances share clock and reset: the
// default 4-bit counter and a 6-bit counter that exercises the wrap with
// a wider modulus. Expected strobes are pushed to a scoreboard queue as
// each edge is driven and popped when the outputs are sampled.
`timescale 1ns/1ps
module tb_pulse_counter;

   typedef struct packed {
      logic [3:0] p4;
      logic [3:0] p6;
   } exp_t;

`ifdef PULSE_COUNTER_COMB_OUT_EN
   localparam int LAT2  = 1;
   localparam int LAT16 = 15;
`else
   localparam int LAT2  = 2;
   localparam int LAT16 = 16;
`endif

   logic clk;
   logic rst;
   logic w4_pulse2, w4_pulse4, w4_pulse8, w4_pulse16;
   logic w6_pulse2, w6_pulse4, w6_pulse8, w6_pulse16;

   exp_t       sb_q[$];
   logic [3:0] m_cnt4;
   logic [5:0] m_cnt6;
   int         checks;
   int         errors;
   int         edge_idx;
   int         rel_edges;
   int         first_lat[4];
   int         last_high4[4];
   int         last_high6[4];
   int         pulse_cnt[4];
   bit         count_en;

   pulse_counter #(.CNT_WIDTH(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .pulse2  (w4_pulse2),
      .pulse4  (w4_pulse4),
      .pulse8  (w4_pulse8),
      .pulse16 (w4_pulse16)
   );

   pulse_counter #(.CNT_WIDTH(6)) u_dut6 (
      .clk     (clk),
      .rst     (rst),
      .pulse2  (w6_pulse2),
      .pulse4  (w6_pulse4),
      .pulse8  (w6_pulse8),
      .pulse16 (w6_pulse16)
   );

   // 2 ns clock period, rising edges at odd nanoseconds.
   initial clk = 1'b0;
   always #1 clk = ~clk;

   // Strobe N is due whenever the low log2(N) bits of the count are all ones.
   function automatic logic [3:0] taps_of(input logic [5:0] c);
      logic [3:0] t;
      logic [5:0] m;
      t = '0;
      for (int i = 0; i < 4; i++) begin
         m    = 6'((1 << (i + 1)) - 1);
         t[i] = ((c & m) == m);
      end
      return t;
   endfunction

   // Compare sampled outputs against the scoreboard and track period,
   // alignment, first-strobe latency and strobe counts.
   task automatic checkOutput(input logic r);
      exp_t       e;
      logic [3:0] o4;
      logic [3:0] o6;
      o4 = {w4_pulse16, w4_pulse8, w4_pulse4, w4_pulse2};
      o6 = {w6_pulse16, w6_pulse8, w6_pulse4, w6_pulse2};
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
         return;
      end
      e = sb_q.pop_front();
      checks++;
      assert (o4 === e.p4) else begin
         errors++;
         $error("[TB] FAIL pulses_w4 edge=%0d observed=%b expected=%b", edge_idx, o4, e.p4);
      end
      checks++;
      assert (o6 === e.p6) else begin
         errors++;
         $error("[TB] FAIL pulses_w6 edge=%0d observed=%b expected=%b", edge_idx, o6, e.p6);
      end
      if (o4[3] === 1'b1) begin
         checks++;
         assert (o4[2:0] === 3'b111) else begin
            errors++;
            $error("[TB] FAIL align16 edge=%0d observed=%b expected=111", edge_idx, o4[2:0]);
         end
      end
      if (o4[2] === 1'b1) begin
         checks++;
         assert (o4[1:0] === 2'b11) else begin
            errors++;
            $error("[TB] FAIL align8 edge=%0d observed=%b expected=11", edge_idx, o4[1:0]);
         end
      end
      if (r) begin
         rel_edges = 0;
         for (int i = 0; i < 4; i++) begin
            first_lat[i]  = -1;
            last_high4[i] = -1;
            last_high6[i] = -1;
         end
      end else begin
         rel_edges++;
         for (int i = 0; i < 4; i++) begin
            if (o4[i] === 1'b1) begin
               if (first_lat[i] < 0) first_lat[i] = rel_edges;
               if (count_en) pulse_cnt[i]++;
               if (last_high4[i] >= 0) begin
                  checks++;
                  assert (edge_idx - last_high4[i] == (1 << (i + 1))) else begin
                     errors++;
                     $error("[TB] FAIL period_w4_%0d observed=%0d expected=%0d", i, edge_idx - last_high4[i], 1 << (i + 1));
                  end
               end
               last_high4[i] = edge_idx;
            end
            if (o6[i] === 1'b1) begin
               if (last_high6[i] >= 0) begin
                  checks++;
                  assert (edge_idx - last_high6[i] == (1 << (i + 1))) else begin
                     errors++;
                     $error("[TB] FAIL period_w6_%0d observed=%0d expected=%0d", i, edge_idx - last_high6[i], 1 << (i + 1));
                  end
               end
               last_high6[i] = edge_idx;
            end
         end
      end
   endtask

   // Drive rst for one rising edge, update the reference model, push the
   // expected strobes and sample the outputs one nanosecond after the edge.
   task automatic applyStimulus(input logic r);
      exp_t e;
      rst = r;
      @(posedge clk);
      edge_idx++;
`ifdef PULSE_COUNTER_COMB_OUT_EN
      if (r) begin
         m_cnt4 = '0;
         m_cnt6 = '0;
      end else begin
         m_cnt4 = m_cnt4 + 4'd1;
         m_cnt6 = m_cnt6 + 6'd1;
      end
      e.p4 = taps_of({2'b00, m_cnt4});
      e.p6 = taps_of(m_cnt6);
`else
      if (r) begin
         m_cnt4 = '0;
         m_cnt6 = '0;
         e.p4   = '0;
         e.p6   = '0;
      end else begin
         e.p4   = taps_of({2'b00, m_cnt4});
         e.p6   = taps_of(m_cnt6);
         m_cnt4 = m_cnt4 + 4'd1;
         m_cnt6 = m_cnt6 + 6'd1;
      end
`endif
      sb_q.push_back(e);
      #1;
      checkOutput(r);
   endtask

   // Check the first strobe latency after the latest reset release.
   task automatic checkLatency(input string tag);
      checks++;
      assert (first_lat[0] === LAT2) else begin
         errors++;
         $error("[TB] FAIL %s_first_pulse2 observed=%0d expected=%0d", tag, first_lat[0], LAT2);
      end
      checks++;
      assert (first_lat[3] === LAT16) else begin
         errors++;
         $error("[TB] FAIL %s_first_pulse16 observed=%0d expected=%0d", tag, first_lat[3], LAT16);
      end
   endtask

   // Check a strobe count over the free run, allowing one either way.
   task automatic checkCount(input int idx, input int nominal);
      checks++;
      assert (pulse_cnt[idx] >= nominal - 1 && pulse_cnt[idx] <= nominal + 1) else begin
         errors++;
         $error("[TB] FAIL count_div%0d observed=%0d expected=%0d+-1", 1 << (idx + 1), pulse_cnt[idx], nominal);
      end
   endtask

   initial begin
      rst       = 1'b1;
      checks    = 0;
      errors    = 0;
      edge_idx  = 0;
      rel_edges = 0;
      count_en  = 1'b0;
      m_cnt4    = '0;
      m_cnt6    = '0;
      for (int i = 0; i < 4; i++) begin
         first_lat[i]  = -1;
         last_high4[i] = -1;
         last_high6[i] = -1;
         pulse_cnt[i]  = 0;
      end

      $display("[TB] reset then free-run for 1000 ns");
      applyStimulus(1'b1);
      count_en = 1'b1;
      repeat (500) applyStimulus(1'b0);
      count_en = 1'b0;
      checkLatency("freerun");
      checkCount(0, 250);
      checkCount(1, 125);
      checkCount(2, 62);
      checkCount(3, 31);

      $display("[TB] mid-run reset at cnt=5");
      for (int k = 0; k < 16 && m_cnt4 != 4'd5; k++) applyStimulus(1'b0);
      applyStimulus(1'b1);
      repeat (20) applyStimulus(1'b0);
      checkLatency("midreset");

      $display("[TB] reset held for 10 edges");
      repeat (10) applyStimulus(1'b1);
      repeat (40) applyStimulus(1'b0);
      checkLatency("longreset");

      $display("[TB] three wraps of the 6-bit counter");
      repeat (192) applyStimulus(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
